// File: rtl/rom_burst_buffer_pkg.sv
// Shared types and AXI encodings for the ROM burst buffer.
package rom_burst_buffer_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_FILL = 2'd2
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/rom_burst_buffer_line_store.sv
// Line data array: one synchronous write port, one asynchronous read port.
module line_store #(
   parameter int LINE_WORDS = 16,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [31:0]      i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [31:0]      o_rdata
);
   logic [31:0] r_mem [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rom_burst_buffer.sv
// rom_burst_buffer: one-line instruction buffer refilled by a single AXI INCR burst.
// Define ROM_BURST_EARLY_RESTART_EN to serve fetches from the line while it is filling.
module rom_burst_buffer
   import rom_burst_buffer_pkg::*;
#(
   parameter int LINE_WORDS = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_en,
   input  logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic                  flush,
   output logic [31:0]           rom_read_data,
   output logic                  rom_ready,
   output logic                  bus_err,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [3:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [31:0]           rdata,
   input  logic                  rlast,
   input  logic [1:0]            rresp
);
   localparam int W     = $clog2(LINE_WORDS);
   localparam int TAG_W = ADDR_WIDTH - W - 2;
   localparam logic [W-1:0] LAST_IDX = W'(LINE_WORDS - 1);

   state_t           r_state, w_state_nxt;
   logic             r_line_valid, r_fill_bad, r_drop_fill, r_bus_err;
   logic [TAG_W-1:0] r_line_tag, r_miss_tag;
   logic [W-1:0]     r_beat_cnt;

   logic [W-1:0]     w_offset;
   logic [TAG_W-1:0] w_tag;
   logic [31:0]      w_arr_data;
   logic             w_hit, w_beat, w_end, w_bad_now, w_er_arr, w_er_byp;
   logic             w_unused;

   assign w_offset = rom_addr[W+1:2];
   assign w_tag    = rom_addr[ADDR_WIDTH-1:W+2];
   assign w_unused = &{1'b0, rom_addr[1:0]};

   // The line is invalidated on leaving IDLE, so a plain hit only occurs in IDLE.
   assign w_hit  = rom_en && r_line_valid && (w_tag == r_line_tag);
   assign w_beat = (r_state == ST_FILL) && rvalid;
   assign w_end  = w_beat && rlast;

   // Overrun (a beat at the last index without rlast) is caught here too.
   assign w_bad_now = r_fill_bad || (rresp != RESP_OKAY) ||
                      (rlast && (r_beat_cnt != LAST_IDX)) ||
                      (!rlast && (r_beat_cnt == LAST_IDX));

`ifdef ROM_BURST_EARLY_RESTART_EN
   logic w_er_match;
   assign w_er_match = (r_state == ST_FILL) && rom_en && !r_drop_fill && (w_tag == r_miss_tag);
   assign w_er_arr   = w_er_match && (w_offset < r_beat_cnt);
   assign w_er_byp   = w_er_match && (w_offset == r_beat_cnt) && rvalid;
`else
   assign w_er_arr = 1'b0;
   assign w_er_byp = 1'b0;
`endif

   line_store #(.LINE_WORDS(LINE_WORDS), .IDX_W(W)) u_line (
      .clk     (clk),
      .i_we    (w_beat),
      .i_waddr (r_beat_cnt),
      .i_wdata (rdata),
      .i_raddr (w_offset),
      .o_rdata (w_arr_data)
   );

   always_comb begin
      rom_ready     = w_hit || w_er_arr || w_er_byp;
      rom_read_data = '0;
      if (w_er_byp)       rom_read_data = rdata;
      else if (rom_ready) rom_read_data = w_arr_data;
   end

   assign bus_err = r_bus_err;

   always_comb begin
      w_state_nxt = r_state;
      arvalid     = 1'b0;
      araddr      = '0;
      arlen       = '0;
      arsize      = '0;
      arburst     = '0;
      rready      = 1'b0;
      case (r_state)
         ST_IDLE: if (rom_en && !w_hit) w_state_nxt = ST_ADDR;
         ST_ADDR: begin
            arvalid = 1'b1;
            araddr  = {r_miss_tag, {(W+2){1'b0}}};
            arlen   = 4'(LINE_WORDS - 1);
            arsize  = SIZE_WORD;
            arburst = BURST_INCR;
            if (arready) w_state_nxt = ST_FILL;
         end
         ST_FILL: begin
            rready = 1'b1;
            if (w_end) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_line_valid <= 1'b0;
         r_line_tag   <= '0;
         r_miss_tag   <= '0;
         r_beat_cnt   <= '0;
         r_fill_bad   <= 1'b0;
         r_drop_fill  <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bus_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rom_en && !w_hit) begin
                  r_miss_tag   <= w_tag;
                  r_line_valid <= 1'b0;
               end
               if (flush) r_line_valid <= 1'b0;
            end
            ST_ADDR: begin
               if (flush) r_line_valid <= 1'b0;
               if (arready) begin
                  r_beat_cnt <= '0;
                  r_fill_bad <= 1'b0;
               end
            end
            ST_FILL: begin
               // AXI cannot abort a burst: a flush here only marks it for discard.
               if (flush) begin
                  r_line_valid <= 1'b0;
                  r_drop_fill  <= 1'b1;
               end
               if (rvalid) begin
                  r_beat_cnt <= r_beat_cnt + W'(1);
                  r_fill_bad <= w_bad_now;
               end
               if (w_end) begin
                  r_drop_fill <= 1'b0;
                  if (!w_bad_now && !r_drop_fill && !flush) begin
                     r_line_valid <= 1'b1;
                     r_line_tag   <= r_miss_tag;
                  end else begin
                     r_line_valid <= 1'b0;
                     r_bus_err    <= w_bad_now;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rom_burst_buffer.sv
// Scoreboard bench for rom_burst_buffer: directed fetches against a small AXI slave model.
module tb_rom_burst_buffer;
`ifdef ROM_BURST_EARLY_RESTART_EN
   localparam bit ER = 1'b1;
`else
   localparam bit ER = 1'b0;
`endif
   localparam logic [31:0] EXP_ATTR = {23'd0, 4'hF, 3'b010, 2'b01};

   logic        clk = 1'b0;
   logic        rst, rom_en, flush, rom_ready, bus_err;
   logic [31:0] rom_addr, rom_read_data;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, rdata;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;

   int tests = 0, fails = 0;
   int ar_cnt = 0, err_cnt = 0, nb = 0;
   int ar_delay, cfg_id, err_beat, flush_beat, n_beats;
   logic [31:0] base;
   logic [31:0] exp_q[$];
   logic [31:0] ar_q[$];

   always #5 clk = ~clk;

   rom_burst_buffer dut (
      .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .flush(flush),
      .rom_read_data(rom_read_data), .rom_ready(rom_ready), .bus_err(bus_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .rlast(rlast), .rresp(rresp)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h, required none", name, act);
   endtask

   // Response and AR-channel checker, driven purely by DUT output activity.
   task automatic mon();
      logic        pw = 1'b0;
      logic [31:0] ha = '0, hattr = '0, attr;
      forever begin
         @(negedge clk);
         attr = {23'd0, arlen, arsize, arburst};
         if (rom_ready) begin
            if (exp_q.size() != 0) chk("rom_read_data", rom_read_data, exp_q.pop_front());
            else bad("spurious_ready", rom_read_data);
         end
         if (arvalid && pw) begin
            chk("ar_hold_addr", araddr, ha);
            chk("ar_hold_attr", attr, hattr);
         end
         if (arvalid && arready) begin
            ar_cnt++;
            if (ar_q.size() != 0) chk("araddr", araddr, ar_q.pop_front());
            else bad("spurious_ar", araddr);
            chk("ar_attr", attr, EXP_ATTR);
         end
         pw    = arvalid && !arready;
         ha    = araddr;
         hattr = attr;
         if (bus_err) err_cnt++;
      end
   endtask

   // AXI slave: beat i of a burst carries base+i; one configured burst may misbehave.
   task automatic slave();
      bit hs, acc, wasl, act = 1'b0;
      int bi = 0, cur = 0, aw = 0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = '0; flush = 1'b0;
      forever begin
         @(negedge clk);
         hs   = arvalid && arready;
         acc  = rvalid && rready;
         wasl = rlast;
         @(posedge clk); #1;
         flush = 1'b0;
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; act = 1'b0; aw = 0;
         end else begin
            if (acc) begin
               if (wasl) act = 1'b0;
               else bi++;
            end
            if (hs) begin
               act = 1'b1; bi = 0; cur = nb; nb++; arready = 1'b0; aw = 0;
            end else if (arvalid) begin
               if (aw >= ar_delay) arready = 1'b1;
               else aw++;
            end
            if (act) begin
               rvalid = 1'b1;
               rdata  = 32'(base + 32'(bi));
               rresp  = (cur == cfg_id && bi == err_beat) ? 2'b10 : 2'b00;
               rlast  = (bi == ((cur == cfg_id) ? n_beats : 16) - 1);
               flush  = (cur == cfg_id && bi == flush_beat);
            end else begin
               rvalid = 1'b0; rlast = 1'b0; rresp = '0;
            end
         end
      end
   endtask

   task automatic cfg(input int e, input int f, input int n);
      cfg_id = nb; err_beat = e; flush_beat = f; n_beats = n;
   endtask

   // Hold rom_en until rom_ready, then compare the observed latency.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
      int n = 0;
      exp_q.push_back(d);
      rom_addr = a;
      rom_en   = 1'b1;
      forever begin
         @(negedge clk);
         if (rom_ready) break;
         n++;
         if (n > 200) begin
            bad("fetch_timeout", a);
            void'(exp_q.pop_back());
            break;
         end
      end
      if (n <= 200) chk("fetch_latency", 32'(n), 32'(lat));
      @(posedge clk); #1;
      rom_en = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      @(negedge clk);
      while ((arvalid || rready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) bad("quiet_timeout", 32'(n));
      @(posedge clk); #1;
   endtask

   initial begin
      int a0, e0, n;
      rst = 1'b1; rom_en = 1'b0; rom_addr = '0; base = '0;
      ar_delay = 0; cfg_id = -1; err_beat = -1; flush_beat = -1; n_beats = 16;
      fork
         mon();
         slave();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_axi_ctl", {23'd0, arvalid, rready, arlen, arsize, arburst}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_ready_err", {30'd0, rom_ready, bus_err}, 32'd0);
      chk("rst_rdata", rom_read_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Cold miss.
      base = 32'h100;
      ar_q.push_back(32'h1FC0_0000);
      fetch(32'h1FC0_0008, 32'h102, ER ? 4 : 18);
      wait_quiet();

      // Whole line hits back to back.
      a0 = ar_cnt;
      for (int i = 0; i < 16; i++) fetch(32'h1FC0_0000 + 32'(4 * i), 32'h100 + 32'(i), 0);
      chk("no_refetch", 32'(ar_cnt), 32'(a0));

      // Next line with arready held off for 5 cycles.
      base = 32'h200; ar_delay = 5;
      ar_q.push_back(32'h1FC0_0040);
      fetch(32'h1FC0_0040, 32'h200, ER ? 7 : 23);
      wait_quiet();
      ar_delay = 0;

      // SLVERR on beat 7.
      base = 32'h300; cfg(7, -1, 16); e0 = err_cnt;
      ar_q.push_back(32'h1FC0_0080);
      if (!ER) ar_q.push_back(32'h1FC0_0080);
      fetch(32'h1FC0_0084, 32'h301, ER ? 3 : 36);
      wait_quiet();
      chk("slverr_pulse", 32'(err_cnt - e0), 32'd1);
      if (ER) ar_q.push_back(32'h1FC0_0080);
      fetch(32'h1FC0_0084, 32'h301, ER ? 3 : 0);
      wait_quiet();

      // Flush during beat 4: drained, discarded, no error.
      base = 32'h400; cfg(-1, 4, 16); e0 = err_cnt;
      ar_q.push_back(32'h1FC0_00C0);
      ar_q.push_back(32'h1FC0_00C0);
      fetch(32'h1FC0_00D4, 32'h405, ER ? 25 : 36);
      wait_quiet();
      chk("flush_no_err", 32'(err_cnt - e0), 32'd0);
      fetch(32'h1FC0_00C0, 32'h400, 0);

      // Early rlast on beat 12.
      base = 32'h500; cfg(-1, -1, 13); e0 = err_cnt;
      ar_q.push_back(32'h1FC0_0100);
      if (!ER) ar_q.push_back(32'h1FC0_0100);
      fetch(32'h1FC0_010C, 32'h503, ER ? 5 : 33);
      wait_quiet();
      chk("short_burst_err", 32'(err_cnt - e0), 32'd1);
      if (ER) ar_q.push_back(32'h1FC0_0100);
      fetch(32'h1FC0_010C, 32'h503, ER ? 5 : 0);
      wait_quiet();

      // Reset in the middle of a fill.
      base = 32'h600;
      ar_q.push_back(32'h1FC0_0140);
      rom_addr = 32'h1FC0_017C; rom_en = 1'b1; n = 0;
      @(negedge clk);
      while (!rready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) bad("rready_timeout", 32'(n));
      @(posedge clk); #1;
      rst = 1'b1; rom_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_burst", {30'd0, arvalid, rready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      base = 32'h500;
      ar_q.push_back(32'h1FC0_0100);
      fetch(32'h1FC0_0100, 32'h500, ER ? 2 : 18);
      wait_quiet();

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("ar_q_empty", 32'(ar_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
